// File: rtl/dyser_input_port.sv
// dyser_input_port: credit-flow-controlled FIFO input port driving a DySER switch link.
module dyser_input_port #(
  parameter int PATH_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CREDITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conf_en,
  input  logic [PATH_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PATH_WIDTH:0]      d_out,
  input  logic                     c_in,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     credit_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  logic [PATH_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] credits;
  logic push, send, sat;
  assign in_ready = (occupancy != (AW+1)'(DEPTH)) && !conf_en;
  assign push = in_valid && in_ready;
  assign send = (occupancy != '0) && (credits != '0) && !conf_en;
  // A credit returned with the counter already full is a protocol error from the switch.
  assign sat = c_in && !send && (credits == CW'(CREDITS));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occupancy <= '0;
      credits <= CW'(CREDITS);
      credit_err <= 1'b0;
      d_out <= '0;
    end else if (conf_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occupancy <= '0;
      credits <= CW'(CREDITS);
      d_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(send);
      credits <= sat ? credits : credits + CW'(c_in) - CW'(send);
      if (sat) credit_err <= 1'b1;
      d_out <= send ? {mem[rd_ptr], 1'b1} : '0;
    end
endmodule

// File: tb/tb_dyser_input_port.sv
// tb_dyser_input_port: directed vector table, reset corner case, then random run against a queue model.
module tb_dyser_input_port;
  localparam int DEPTH = 4;
  localparam int CREDITS = 2;
  logic clk = 0, rst = 1, conf_en = 0, in_valid = 0, c_in = 0;
  logic [63:0] in_data = '0;
  logic in_ready, credit_err;
  logic [64:0] d_out;
  logic [2:0] occupancy;
  int errors = 0, checks = 0;
  dyser_input_port dut (
    .clk(clk), .rst(rst), .conf_en(conf_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .d_out(d_out), .c_in(c_in), .occupancy(occupancy), .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic conf, valid, c;
    logic [63:0] data;
    logic dv;
    logic [63:0] dd;
    int occ;
    logic rdy, err;
  } vec_t;
  vec_t tbl[$];
  logic [63:0] q[$];
  int cred;
  logic m_err;
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic conf, valid, c, input logic [63:0] data, input logic dv,
                     input logic [63:0] dd, input int occ, input logic rdy, err);
    tbl.push_back('{conf, valid, c, data, dv, dd, occ, rdy, err});
  endtask
  task automatic step(input logic conf, valid, c, input logic [63:0] data);
    conf_en = conf;
    in_valid = valid;
    c_in = c;
    in_data = data;
    @(posedge clk);
    #1;
  endtask
  task automatic model_edge(input logic conf, valid, c, input logic [63:0] data, output logic [64:0] exp_d);
    logic ready, snd;
    ready = (q.size() < DEPTH) && !conf;
    snd = (q.size() > 0) && (cred > 0) && !conf;
    exp_d = '0;
    if (conf) begin
      q.delete();
      cred = CREDITS;
    end else begin
      if (snd) exp_d = {q.pop_front(), 1'b1};
      if (valid && ready) q.push_back(data);
      if (c && !snd && cred == CREDITS) m_err = 1'b1;
      else cred = cred + int'(c) - int'(snd);
    end
  endtask
  initial begin
    logic [64:0] exp_d;
    logic [63:0] x;
    add(0,1,0,64'h1234, 0,0,1,1,0);
    add(0,0,0,0, 1,64'h1234,0,1,0);
    add(0,0,0,0, 0,0,0,1,0);
    add(0,0,1,0, 0,0,0,1,0);
    add(0,1,0,64'h11, 0,0,1,1,0);
    add(0,1,0,64'h22, 1,64'h11,1,1,0);
    add(0,1,0,64'h33, 1,64'h22,1,1,0);
    add(0,1,0,64'h44, 0,0,2,1,0);
    add(0,0,0,0, 0,0,2,1,0);
    add(0,0,1,0, 0,0,2,1,0);
    add(0,0,0,0, 1,64'h33,1,1,0);
    add(0,0,0,0, 0,0,1,1,0);
    add(0,1,0,64'h55, 0,0,2,1,0);
    add(0,1,0,64'h66, 0,0,3,1,0);
    add(0,1,0,64'h77, 0,0,4,0,0);
    add(0,1,0,64'h88, 0,0,4,0,0);
    add(0,0,1,0, 0,0,4,0,0);
    add(0,0,1,0, 1,64'h44,3,1,0);
    add(0,0,1,0, 1,64'h55,2,1,0);
    add(0,0,1,0, 1,64'h66,1,1,0);
    add(0,0,1,0, 1,64'h77,0,1,0);
    add(0,0,1,0, 0,0,0,1,0);
    add(0,0,1,0, 0,0,0,1,1);
    add(0,0,0,0, 0,0,0,1,1);
    add(0,1,0,64'h99, 0,0,1,1,1);
    add(0,0,1,0, 1,64'h99,0,1,1);
    add(0,1,0,64'hAA, 0,0,1,1,1);
    add(0,1,0,64'hBB, 1,64'hAA,1,1,1);
    add(0,0,0,0, 1,64'hBB,0,1,1);
    add(0,1,0,64'hCC, 0,0,1,1,1);
    add(0,0,0,0, 0,0,1,1,1);
    add(0,1,0,64'hDD, 0,0,2,1,1);
    add(0,1,0,64'hEE, 0,0,3,1,1);
    add(1,1,0,64'hFF, 0,0,0,0,1);
    add(0,0,0,0, 0,0,0,1,1);
    add(0,1,0,64'h101, 0,0,1,1,1);
    add(0,1,0,64'h102, 1,64'h101,1,1,1);
    add(0,1,0,64'h103, 1,64'h102,1,1,1);
    add(0,0,0,0, 0,0,1,1,1);
    #2;
    chk("reset d_out", d_out, 65'd0);
    chk("reset occupancy", 65'(occupancy), 65'd0);
    chk("reset in_ready", 65'(in_ready), 65'd1);
    chk("reset credit_err", 65'(credit_err), 65'd0);
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) begin
      step(tbl[i].conf, tbl[i].valid, tbl[i].c, tbl[i].data);
      chk($sformatf("vec%0d d_out", i), d_out, tbl[i].dv ? {tbl[i].dd, 1'b1} : 65'd0);
      chk($sformatf("vec%0d occupancy", i), 65'(occupancy), 65'(tbl[i].occ));
      chk($sformatf("vec%0d in_ready", i), 65'(in_ready), 65'(tbl[i].rdy));
      chk($sformatf("vec%0d credit_err", i), 65'(credit_err), 65'(tbl[i].err));
    end
    step(0, 0, 1, 0);
    step(0, 1, 0, 64'h104);
    chk("pre-reset d_out", d_out, {64'h103, 1'b1});
    chk("pre-reset occupancy", 65'(occupancy), 65'd1);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async reset d_out", d_out, 65'd0);
    chk("async reset in_ready", 65'(in_ready), 65'd1);
    chk("async reset occupancy", 65'(occupancy), 65'd0);
    chk("async reset credit_err", 65'(credit_err), 65'd0);
    @(negedge clk);
    rst = 0;
    step(0, 1, 0, 64'hDEAD_BEEF_CAFE_F00D);
    step(0, 0, 0, 0);
    chk("post-reset word", d_out, {64'hDEAD_BEEF_CAFE_F00D, 1'b1});
    step(0, 0, 0, 0);
    chk("post-reset idle", d_out, 65'd0);
    rst = 1;
    #2;
    @(negedge clk);
    rst = 0;
    q.delete();
    cred = CREDITS;
    m_err = 0;
    for (int i = 0; i < 400; i++) begin
      logic cf, v, c;
      cf = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 45);
      x = {$urandom, $urandom};
      conf_en = cf;
      in_valid = v;
      c_in = c;
      in_data = x;
      #1;
      chk($sformatf("rnd%0d in_ready", i), 65'(in_ready), 65'((q.size() < DEPTH) && !cf));
      model_edge(cf, v, c, x, exp_d);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d d_out", i), d_out, exp_d);
      chk($sformatf("rnd%0d occupancy", i), 65'(occupancy), 65'(q.size()));
      chk($sformatf("rnd%0d credit_err", i), 65'(credit_err), 65'(m_err));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
